ecc_data_channel: RTL and testbench

ECC_DATA_CHANNEL -- requirements
Module: ecc_data_channel

---
 rtl/ecc_data_channel.sv | 192 +++++++++++++++++++
 tb/tb_ecc_data_channel.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_data_channel.sv
// ecc_data_channel: two-stage SECDED-protected data channel with error counters.
//
// Each accepted word is Hamming-encoded (parity at power-of-two positions 1..CW-1,
// even parity, bit 0 = overall even parity), optionally corrupted by inj_mask_i, and
// registered in S1. S2 registers the decode result. Single errors are corrected,
// double errors are flagged and passed through raw.
//
// Build option: define ECC_ERR_INJECT_EN to apply inj_mask_i on the channel. When it
// is undefined the mask port is kept but ignored and the channel is error-free.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_valid_i/ready_o  upstream handshake, in_data_i payload, inj_mask_i bit flips
//   out_valid_o/ready_i downstream handshake, out_data_o corrected payload
//   err_corr_o          single error corrected (qualified by out_valid_o)
//   err_uncorr_o        uncorrectable error detected (qualified by out_valid_o)
//   clr_cnt_i           synchronous clear of both counters
//   corr_cnt_o          saturating count of err_corr_o transfers
//   uncorr_cnt_o        saturating count of err_uncorr_o transfers
module ecc_data_channel #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W + P + 1, valid for DATA_W in 4..64.
    localparam int unsigned P  = (DATA_W <= 4)  ? 3 :
                                 (DATA_W <= 11) ? 4 :
                                 (DATA_W <= 26) ? 5 :
                                 (DATA_W <= 57) ? 6 : 7,
    localparam int unsigned CW = DATA_W + P + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CW-1:0]     inj_mask_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              err_corr_o,
    output logic              err_uncorr_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  corr_cnt_o,
    output logic [CNT_W-1:0]  uncorr_cnt_o
);

    logic              s1_valid_q, s1_valid_d;
    logic [CW-1:0]     s1_cw_q, s1_cw_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_corr_q, s2_corr_d;
    logic              s2_uncorr_q, s2_uncorr_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic              s1_adv, in_fire, out_fire;
    logic [CW-1:0]     enc_cw, chan_cw, fixed_cw;
    logic [DATA_W-1:0] enc_rem, dec_data;
    logic [P-1:0]      syn;
    logic              par_bad, in_range, dec_corr, dec_uncorr;

    // Handshake: S1 may move on whenever S2 is empty or draining this cycle.
    assign s1_adv   = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = s2_valid_q && out_ready_i;

    // Encoder: data fills non-power-of-two positions LSB first.
    always_comb begin
        enc_cw  = '0;
        enc_rem = in_data_i;
        for (int j = 1; j < CW; j++) begin
            if ((j & (j - 1)) != 0) begin
                enc_cw[j] = enc_rem[0];
                enc_rem   = enc_rem >> 1;
            end
        end
        for (int k = 0; k < P; k++) begin
            for (int j = 1; j < CW; j++) begin
                if (j[k] && (j != (1 << k))) begin
                    enc_cw[1 << k] = enc_cw[1 << k] ^ enc_cw[j];
                end
            end
        end
        enc_cw[0] = ^enc_cw[CW-1:1];
    end

`ifdef ECC_ERR_INJECT_EN
    assign chan_cw = enc_cw ^ inj_mask_i;
`else
    assign chan_cw = enc_cw;
    logic unused_inj;
    assign unused_inj = ^inj_mask_i;
`endif

    // Decoder on the S1 codeword.
    always_comb begin
        syn = '0;
        for (int j = 1; j < CW; j++) begin
            if (s1_cw_q[j]) begin
                syn = syn ^ P'(j);
            end
        end
        par_bad    = ^s1_cw_q;
        in_range   = (32'(syn) < CW);
        // Odd parity with a syndrome past the last position cannot be a single flip.
        dec_corr   = par_bad && in_range;
        dec_uncorr = (par_bad && !in_range) || (!par_bad && (syn != '0));
        fixed_cw   = s1_cw_q;
        for (int j = 0; j < CW; j++) begin
            if (dec_corr && (syn == P'(j))) begin
                fixed_cw[j] = !fixed_cw[j];
            end
        end
        // Shift data bits in from the top so the first data position lands in bit 0.
        dec_data = '0;
        for (int j = 1; j < CW; j++) begin
            if ((j & (j - 1)) != 0) begin
                dec_data = {fixed_cw[j], dec_data[DATA_W-1:1]};
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_cw_d     = s1_cw_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_corr_d   = s2_corr_q;
        s2_uncorr_d = s2_uncorr_q;
        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
        end
        if (in_fire) begin
            s1_cw_d = chan_cw;
        end
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d   = dec_data;
                s2_corr_d   = dec_corr;
                s2_uncorr_d = dec_uncorr;
            end
        end
    end

    // Counters saturate; clear takes priority over a same-cycle increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (out_fire && s2_corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (out_fire && s2_uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_corr_q    <= 1'b0;
            s2_uncorr_q  <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_corr_q    <= s2_corr_d;
            s2_uncorr_q  <= s2_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign out_data_o   = s2_data_q;
    assign err_corr_o   = s2_corr_q;
    assign err_uncorr_o = s2_uncorr_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_data_channel.sv
// Directed bench for ecc_data_channel (DATA_W=8, CW=13, CNT_W=4 for saturation).
// Expectations adapt to whether ECC_ERR_INJECT_EN is defined for the build.
module tb_ecc_data_channel;

`ifdef ECC_ERR_INJECT_EN
    localparam bit Inj = 1'b1;
`else
    localparam bit Inj = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [12:0] inj_mask = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        err_corr, err_uncorr;
    logic        clr_cnt = 1'b0;
    logic [3:0]  corr_cnt, uncorr_cnt;

    logic        rdy_man = 1'b0;
    logic        stall_en = 1'b0;
    logic        stall_bit = 1'b1;
    int          stall_k = 0;
    logic        lat_chk = 1'b0;
    int          cyc = 0;
    int          delivered = 0;
    int          tests = 0;
    int          fails = 0;

    logic [7:0]  cur_ed;
    logic        cur_ec, cur_eu;

    typedef struct {
        logic [7:0]  d;
        logic [12:0] m;
        logic [7:0]  ed;
        logic        ec;
        logic        eu;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       u;
        int         cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t q[$];

    ecc_data_channel #(
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .inj_mask_i   (inj_mask),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .err_corr_o   (err_corr),
        .err_uncorr_o (err_uncorr),
        .clr_cnt_i    (clr_cnt),
        .corr_cnt_o   (corr_cnt),
        .uncorr_cnt_o (uncorr_cnt)
    );

    always #5 clk = ~clk;

    assign out_ready = stall_en ? stall_bit : rdy_man;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready pattern 1,0,0,1 repeating while stalling is enabled.
    always @(posedge clk) begin
        #1;
        if (stall_en) begin
            stall_bit = ((stall_k % 4) == 0) || ((stall_k % 4) == 3);
            stall_k++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: in-order expected words, readiness model and latency.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_model", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !out_ready)});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", {24'b0, out_data}, {24'b0, e.d});
                    chk("err_corr", {31'b0, err_corr}, {31'b0, e.c});
                    chk("err_uncorr", {31'b0, err_uncorr}, {31'b0, e.u});
                    if (lat_chk) chk("latency", cyc - e.cyc, 32'd2);
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{d: cur_ed, c: cur_ec, u: cur_eu, cyc: cyc});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept, in_valid left high.
    task automatic send(input logic [7:0] d, input logic [12:0] m, input logic [7:0] ed,
                        input logic ec, input logic eu);
        int g;
        in_valid = 1'b1;
        in_data  = d;
        inj_mask = m;
        cur_ed   = ed;
        cur_ec   = ec;
        cur_eu   = eu;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            g++;
            @(negedge clk);
        end
        chk("send_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        inj_mask = '0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [12:0] m,
                                input logic [7:0] ed, input logic ec, input logic eu);
        vec_t v;
        v.d  = d;
        v.m  = m;
        v.ed = Inj ? ed : d;
        v.ec = Inj ? ec : 1'b0;
        v.eu = Inj ? eu : 1'b0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean stream, then single/double/out-of-range/parity-bit errors.
        vecs.push_back(mk(8'h00, 13'h0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'hAA, 13'h0000, 8'hAA, 1'b0, 1'b0));
        vecs.push_back(mk(8'hCC, 13'h0000, 8'hCC, 1'b0, 1'b0));
        vecs.push_back(mk(8'hF0, 13'h0000, 8'hF0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h55, 13'h0000, 8'h55, 1'b0, 1'b0));
        vecs.push_back(mk(8'hDA, 13'h0000, 8'hDA, 1'b0, 1'b0));
        vecs.push_back(mk(8'hFF, 13'h0000, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(8'hAA, 13'h0008, 8'hAA, 1'b1, 1'b0));
        vecs.push_back(mk(8'hAA, 13'h0001, 8'hAA, 1'b1, 1'b0));
        vecs.push_back(mk(8'hFF, 13'h1000, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(8'h5A, 13'h0200, 8'h5A, 1'b1, 1'b0));
        vecs.push_back(mk(8'hCC, 13'h0006, 8'hCC, 1'b0, 1'b1));
        vecs.push_back(mk(8'hAA, 13'h0028, 8'hA9, 1'b0, 1'b1));
        vecs.push_back(mk(8'h00, 13'h1003, 8'h80, 1'b0, 1'b1));
        vecs.push_back(mk(8'h3C, 13'h0003, 8'h3C, 1'b0, 1'b1));

        // Reset values.
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_err_corr", {31'b0, err_corr}, 32'd0);
        chk("rst_err_uncorr", {31'b0, err_uncorr}, 32'd0);
        chk("rst_corr_cnt", {28'b0, corr_cnt}, 32'd0);
        chk("rst_uncorr_cnt", {28'b0, uncorr_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_man = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back table with out_ready held high; latency checked.
        lat_chk = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].d, vecs[i].m, vecs[i].ed, vecs[i].ec, vecs[i].eu);
            if (i == 6) begin
                idle();
                drain();
                chk("clean_corr_cnt", {28'b0, corr_cnt}, 32'd0);
                chk("clean_uncorr_cnt", {28'b0, uncorr_cnt}, 32'd0);
            end
            if (i == 8) begin
                idle();
                drain();
                chk("two_single_corr_cnt", {28'b0, corr_cnt}, Inj ? 32'd2 : 32'd0);
            end
        end
        idle();
        drain();
        chk("table_corr_cnt", {28'b0, corr_cnt}, Inj ? 32'd4 : 32'd0);
        chk("table_uncorr_cnt", {28'b0, uncorr_cnt}, Inj ? 32'd4 : 32'd0);
        lat_chk = 1'b0;

        // Reset with two words in flight.
        rdy_man = 1'b0;
        send(8'h11, 13'h0, 8'h11, 1'b0, 1'b0);
        send(8'h22, 13'h0, 8'h22, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_corr_cnt", {28'b0, corr_cnt}, 32'd0);
        chk("mid_rst_uncorr_cnt", {28'b0, uncorr_cnt}, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_man = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Stalled stream: order and exactly-once delivery.
        delivered = 0;
        stall_k   = 0;
        stall_bit = 1'b1;
        stall_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h13 * i + 1), 13'h0, 8'(8'h13 * i + 1), 1'b0, 1'b0);
        end
        idle();
        drain();
        stall_en = 1'b0;
        chk("stall_delivered", delivered, 32'd8);

        // Saturation with the 4-bit counter, then clear racing an increment.
        clr_cnt = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_corr_cnt", {28'b0, corr_cnt}, 32'd0);
        chk("clr_uncorr_cnt", {28'b0, uncorr_cnt}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            send(8'h55, 13'h0010, 8'h55, Inj, 1'b0);
        end
        idle();
        drain();
        chk("sat16_corr_cnt", {28'b0, corr_cnt}, Inj ? 32'd15 : 32'd0);
        send(8'h55, 13'h0010, 8'h55, Inj, 1'b0);
        idle();
        drain();
        chk("sat17_corr_cnt", {28'b0, corr_cnt}, Inj ? 32'd15 : 32'd0);

        rdy_man = 1'b0;
        send(8'h66, 13'h0010, 8'h66, Inj, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("clr_race_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        rdy_man = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_race_corr_cnt", {28'b0, corr_cnt}, 32'd0);
        chk("clr_race_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
